checker_arbiter: RTL and testbench

- Shares one `cpu_checker`-style character checker between N_REQ independent trace-character sources.
- Grants the checker one whole message at a time, round-robin, so messages never interleave.
- Clears the checker before each message and streams that requester's characters until `#`.
- Reports the checker's verdict tagged with the requester id. Sits between trace generators and the single checker instance in the verification harness.

---
 rtl/checker_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_checker_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/checker_arbiter.sv
// Round-robin arbiter sharing one character checker between N_REQ trace sources, one whole
// message at a time. Define CHK_STAT_EN to add per-requester pass / shared fail counters.
module checker_arbiter #(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned MAX_LEN = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_char,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 chk_reset,
    output logic [7:0]           chk_char,
    input  logic [1:0]           chk_format_type,
    output logic                 result_valid,
    output logic [1:0]           result_id,
    output logic [1:0]           result_type,
    output logic [1:0]           result_err
`ifdef CHK_STAT_EN
    ,
    output logic [16*N_REQ-1:0]  stat_ok,
    output logic [15:0]          stat_bad
`endif
);

    typedef enum logic [1:0] {StIdle, StClear, StStream, StResult} state_e;

    localparam logic [1:0] ErrOk      = 2'b00;
    localparam logic [1:0] ErrAbort   = 2'b01;
    localparam logic [1:0] ErrTimeout = 2'b10;
    localparam logic [7:0] CharEnd    = 8'h23;

    state_e       state_q, state_d;
    logic [1:0]   ptr_q, ptr_d;
    logic [1:0]   grant_q, grant_d;
    logic [7:0]   len_q, len_d;
    logic [1:0]   err_q, err_d;

    logic [1:0]       pick;
    logic             found;
    logic             gnt_valid;
    logic [7:0]       gnt_char;
    logic [N_REQ-1:0] gnt_sel;
    logic [7:0]       len_inc;

    assign len_inc = len_q + 8'd1;

    // Search starts one past the last served requester and wraps.
    always_comb begin
        int unsigned cand;
        pick  = ptr_q;
        found = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(ptr_q) + k) % N_REQ;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!found && cand == i && req_valid[i]) begin
                    pick  = 2'(i);
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt_char  = 8'h00;
        gnt_sel   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_q == 2'(i)) begin
                gnt_sel[i] = 1'b1;
                gnt_valid  = req_valid[i];
                gnt_char   = req_char[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= 2'(N_REQ - 1);
            grant_q <= 2'b00;
            len_q   <= 8'h00;
            err_q   <= ErrOk;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        len_d   = len_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = pick;
                    state_d = StClear;
                end
            end
            StClear: begin
                len_d   = 8'h00;
                state_d = StStream;
            end
            StStream: begin
                // The checker cannot be stalled, so a missing character aborts the message.
                if (gnt_valid) begin
                    len_d = len_inc;
                    if (gnt_char == CharEnd) begin
                        err_d   = ErrOk;
                        state_d = StResult;
                    end else if (len_inc == 8'(MAX_LEN)) begin
                        err_d   = ErrTimeout;
                        state_d = StResult;
                    end
                end else begin
                    err_d   = ErrAbort;
                    state_d = StResult;
                end
            end
            StResult: begin
                ptr_d   = grant_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready    = '0;
        chk_char     = 8'h00;
        result_valid = 1'b0;
        result_id    = 2'b00;
        result_type  = 2'b00;
        result_err   = 2'b00;
        unique case (state_q)
            StStream: begin
                if (gnt_valid) begin
                    req_ready = gnt_sel;
                    chk_char  = gnt_char;
                end
            end
            StResult: begin
                result_valid = 1'b1;
                result_id    = grant_q;
                result_err   = err_q;
                result_type  = (err_q == ErrOk) ? chk_format_type : 2'b00;
            end
            default: ;
        endcase
        chk_reset = reset | (state_q == StClear);
    end

`ifdef CHK_STAT_EN
    logic [16*N_REQ-1:0] stat_ok_q;
    logic [15:0]         stat_bad_q;
    logic                count_ok;

    assign count_ok = (err_q == ErrOk) && (chk_format_type != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_ok_q  <= '0;
            stat_bad_q <= 16'h0000;
        end else if (state_q == StResult) begin
            if (count_ok) begin
                for (int unsigned i = 0; i < N_REQ; i++) begin
                    if (grant_q == 2'(i) && stat_ok_q[16*i +: 16] != 16'hFFFF) begin
                        stat_ok_q[16*i +: 16] <= stat_ok_q[16*i +: 16] + 16'd1;
                    end
                end
            end else if (stat_bad_q != 16'hFFFF) begin
                stat_bad_q <= stat_bad_q + 16'd1;
            end
        end
    end

    assign stat_ok  = stat_ok_q;
    assign stat_bad = stat_bad_q;
`endif

endmodule

// File: tb/tb_checker_arbiter.sv
// Directed bench for checker_arbiter: message table driven through a cycle-stepped requester
// model, plus hand-written reset, back-to-back and MAX_LEN sequences.
module tb_checker_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [15:0] req_char;
    logic [1:0]  fmt;

    logic [1:0]  ready_a, ready_b;
    logic        chk_reset_a, chk_reset_b;
    logic [7:0]  chk_char_a, chk_char_b;
    logic        rv_a, rv_b;
    logic [1:0]  rid_a, rid_b, rty_a, rty_b, rer_a, rer_b;
`ifdef CHK_STAT_EN
    logic [31:0] stat_ok_a, stat_ok_b;
    logic [15:0] stat_bad_a, stat_bad_b;
`endif

    checker_arbiter #(.N_REQ(2), .MAX_LEN(64)) u_dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_char(req_char),
        .req_ready(ready_a), .chk_reset(chk_reset_a), .chk_char(chk_char_a),
        .chk_format_type(fmt), .result_valid(rv_a), .result_id(rid_a),
        .result_type(rty_a), .result_err(rer_a)
`ifdef CHK_STAT_EN
        , .stat_ok(stat_ok_a), .stat_bad(stat_bad_a)
`endif
    );

    checker_arbiter #(.N_REQ(2), .MAX_LEN(8)) u_dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_char(req_char),
        .req_ready(ready_b), .chk_reset(chk_reset_b), .chk_char(chk_char_b),
        .chk_format_type(fmt), .result_valid(rv_b), .result_id(rid_b),
        .result_type(rty_b), .result_err(rer_b)
`ifdef CHK_STAT_EN
        , .stat_ok(stat_ok_b), .stat_bad(stat_bad_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        string      msg;
        int         stop;
        logic [1:0] fmt;
        logic [1:0] exp_type;
        logic [1:0] exp_err;
        int         exp_acc;
        int         exp_lat;
    } vec_t;

    typedef struct {
        int         id;
        logic [1:0] typ;
        logic [1:0] err;
        int         cyc;
        int         acc;
        int         lat;
    } res_t;

    vec_t       tbl [9];
    res_t       resq [$];
    string      cur_msg [2];
    int         cur_idx [2];
    int         cur_stop [2];
    logic [1:0] cur_fmt [2];
    int         first_xfer [2];
    int         last_xfer [2];
    int         last_id;
    logic       prev_rst;
    logic [1:0] mon_rdy;
    int         cyc;
    bit         sel_b;
    int         total;
    int         bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic load(input int k);
        int id;
        id = tbl[k].id;
        cur_msg[id]  = tbl[k].msg;
        cur_idx[id]  = 0;
        cur_stop[id] = (tbl[k].stop < 0) ? tbl[k].msg.len() : tbl[k].stop;
        cur_fmt[id]  = tbl[k].fmt;
    endtask

    task automatic clear_drivers();
        for (int i = 0; i < 2; i++) begin
            cur_idx[i]  = 0;
            cur_stop[i] = 0;
            cur_fmt[i]  = 2'b00;
        end
        last_id = 0;
    endtask

    // One clock cycle: drive at posedge+1, observe at negedge, return at next posedge+1.
    task automatic step();
        logic [1:0] rdy;
        logic [7:0] cc;
        logic       cr;
        logic       rv;
        logic [1:0] rid, rty, rer;
        res_t       r;
        int         id;
        for (int i = 0; i < 2; i++) begin
            if (cur_idx[i] < cur_stop[i]) begin
                req_valid[i]       = 1'b1;
                req_char[8*i +: 8] = cur_msg[i][cur_idx[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_char[8*i +: 8] = 8'h00;
            end
        end
        fmt = cur_fmt[last_id];
        @(negedge clk);
        rdy = sel_b ? ready_b : ready_a;
        cc  = sel_b ? chk_char_b : chk_char_a;
        cr  = sel_b ? chk_reset_b : chk_reset_a;
        rv  = sel_b ? rv_b : rv_a;
        rid = sel_b ? rid_b : rid_a;
        rty = sel_b ? rty_b : rty_a;
        rer = sel_b ? rer_b : rer_a;
        mon_rdy = rdy;
        if (rdy != 2'b00) begin
            check("single_ready", 32'($countones(rdy)), 32'd1);
            id = rdy[1] ? 1 : 0;
            check("ready_needs_valid", 32'(req_valid[id]), 32'd1);
            check("chk_char", 32'(cc), 32'(cur_msg[id][cur_idx[id]]));
            if (cur_idx[id] == 0) begin
                check("clear_before_msg", 32'(prev_rst), 32'd1);
                first_xfer[id] = cyc;
            end else begin
                check("no_interleave", 32'(last_id), 32'(id));
            end
            last_xfer[id] = cyc;
            cur_idx[id]++;
            last_id = id;
        end else begin
            check("chk_char_idle", 32'(cc), 32'd0);
        end
        if (rv) begin
            check("result_id_hi", 32'(rid[1]), 32'd0);
            r.id  = int'(rid);
            r.typ = rty;
            r.err = rer;
            r.cyc = cyc;
            r.acc = cur_idx[rid[0]];
            r.lat = cyc - last_xfer[rid[0]];
            resq.push_back(r);
        end
        prev_rst = cr;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int n);
        int b;
        b = 0;
        while (resq.size() < n && b < 400) begin
            step();
            b++;
        end
        check("result_count", 32'(resq.size()), 32'(n));
    endtask

    task automatic verify(input int k);
        res_t r;
        if (resq.size() == 0) begin
            check("missing_result", 32'd0, 32'd1);
            return;
        end
        r = resq.pop_front();
        check("result_id", 32'(r.id), 32'(tbl[k].id));
        check("result_type", 32'(r.typ), 32'(tbl[k].exp_type));
        check("result_err", 32'(r.err), 32'(tbl[k].exp_err));
        check("accepted_chars", 32'(r.acc), 32'(tbl[k].exp_acc));
        check("result_latency", 32'(r.lat), 32'(tbl[k].exp_lat));
    endtask

    task automatic rst_checks();
        check("rst_ready_a", 32'(ready_a), 32'd0);
        check("rst_chk_char_a", 32'(chk_char_a), 32'd0);
        check("rst_chk_reset_a", 32'(chk_reset_a), 32'd1);
        check("rst_result_valid_a", 32'(rv_a), 32'd0);
        check("rst_result_fields_a", 32'({rid_a, rty_a, rer_a}), 32'd0);
        check("rst_ready_b", 32'(ready_b), 32'd0);
        check("rst_chk_reset_b", 32'(chk_reset_b), 32'd1);
`ifdef CHK_STAT_EN
        check("rst_stat_ok", stat_ok_a, 32'd0);
        check("rst_stat_bad", 32'(stat_bad_a), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int rc;
        tbl[0] = '{0, "^10@00003000:$ 5 <= 0000000a#", -1, 2'b01, 2'b01, 2'b00, 29, 1};
        tbl[1] = '{1, "^7@00003004: *00000010 <=00000020#", -1, 2'b10, 2'b10, 2'b00, 34, 1};
        tbl[2] = '{0, "^12@0000300g:$1<=00000001#", -1, 2'b00, 2'b00, 2'b00, 26, 1};
        tbl[3] = '{0, "^10@00003000:$ 5 <= 0000000a#", -1, 2'b01, 2'b01, 2'b00, 29, 1};
        tbl[4] = '{1, "^3@0000", -1, 2'b01, 2'b00, 2'b01, 7, 2};
        tbl[5] = '{0, "^12@0000300g:$1<=00000001#", -1, 2'b01, 2'b01, 2'b00, 26, 1};
        tbl[6] = '{1, "^3@0000#", -1, 2'b10, 2'b10, 2'b00, 8, 1};
        tbl[7] = '{1, "1234567#", -1, 2'b10, 2'b10, 2'b00, 8, 1};
        tbl[8] = '{0, "0123456789", -1, 2'b01, 2'b00, 2'b10, 8, 1};

        total = 0;
        bad = 0;
        cyc = 0;
        sel_b = 1'b0;
        prev_rst = 1'b0;
        req_valid = 2'b00;
        req_char = 16'h0000;
        fmt = 2'b00;
        clear_drivers();

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_checks();
        reset = 1'b0;
        #1;
        check("idle_chk_reset", 32'(chk_reset_a), 32'd0);

        // Both requesters valid from reset: req0 first, then req1.
        c0 = cyc;
        load(0);
        load(1);
        run_until(2);
        check("grant_latency", 32'(first_xfer[0]), 32'(c0 + 2));
        verify(0);
        verify(1);

        // Single active requester re-granted back-to-back.
        load(2);
        run_until(1);
        rc = resq[0].cyc;
        verify(2);
        load(3);
        run_until(1);
        check("regrant_gap", 32'(first_xfer[0]), 32'(rc + 3));
        verify(3);

        // Requester drops valid mid-message.
        load(4);
        run_until(1);
        verify(4);

`ifdef CHK_STAT_EN
        check("stat_ok0", 32'(stat_ok_a[15:0]), 32'd2);
        check("stat_ok1", 32'(stat_ok_a[31:16]), 32'd1);
        check("stat_bad", 32'(stat_bad_a), 32'd2);
`endif

        // Asynchronous reset in the middle of a stream.
        load(1);
        repeat (10) step();
        check("midstream_ready", 32'(ready_a), 32'b10);
        #2;
        reset = 1'b1;
        #1;
        rst_checks();
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_drivers();
        repeat (3) step();
        check("no_result_after_reset", 32'(resq.size()), 32'd0);
        load(5);
        load(6);
        run_until(2);
        verify(5);
        verify(6);

        // MAX_LEN=8 instance: '#' on the last allowed character, then a timeout.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_drivers();
        resq.delete();
        sel_b = 1'b1;
        load(7);
        run_until(1);
        verify(7);
        load(8);
        run_until(1);
        verify(8);
        step();
        check("timeout_ready_low_idle", 32'(mon_rdy), 32'd0);
        step();
        check("timeout_ready_low_clear", 32'(mon_rdy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
